// File: rtl/btb_sat_predictor.sv
// Fully associative branch target buffer with 2-bit saturating direction
// counters. Lookups return a registered prediction one cycle after the
// request. Updates come from the branch resolver. A flush invalidates the
// whole table. Allocation uses the lowest free slot. When the table is full,
// a round-robin victim pointer picks the slot to replace.
module btb_sat_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3,
    parameter int PC_STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lk_valid,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [ADDR_W-1:0] lk_next_pc,
    output logic              lk_rvalid,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken,
    input  logic              flush,
    output logic [IDX_W:0]    occupancy,
    output logic              full
);

    localparam int OCC_W = IDX_W + 1;

    // Table state
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  tag_d    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [ADDR_W-1:0]  target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [IDX_W-1:0]   victim_q, victim_d;
    logic [OCC_W-1:0]   occupancy_q, occupancy_d;
    logic               full_q;

    // Registered lookup outputs
    logic              lk_hit_q, lk_taken_q, lk_rvalid_q;
    logic [ADDR_W-1:0] lk_next_pc_q;

    // Combinational search results
    logic             upd_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] alloc_idx;
    logic             lk_match;
    logic [IDX_W-1:0] lk_idx;

    // Parallel tag compare for both ports, plus the lowest-index free slot
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        upd_hit  = 1'b0;
        upd_idx  = '0;
        lk_match = 1'b0;
        lk_idx   = '0;
        free_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == upd_pc) begin
                upd_hit = 1'b1;
                upd_idx = IDX_W'(i);
            end
            if (valid_q[i] && tag_q[i] == lk_pc) begin
                lk_match = 1'b1;
                lk_idx   = IDX_W'(i);
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    // Next table state: flush wins, then hit-update, then allocation on a taken miss
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        victim_d  = victim_q;
        alloc_idx = full_q ? victim_q : free_idx;
        if (flush) begin
            valid_d  = '0;
            victim_d = '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
                    target_d[upd_idx] = upd_target;
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_d[alloc_idx]  = 1'b1;
                tag_d[alloc_idx]    = upd_pc;
                target_d[alloc_idx] = upd_target;
                ctr_d[alloc_idx]    = 2'b10;
                if (full_q) victim_d = victim_q + IDX_W'(1);
            end
        end
        occupancy_d = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            occupancy_d = occupancy_d + OCC_W'(valid_d[i]);
        end
    end

    // Table registers, victim pointer and registered occupancy/full flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table arrays are reset too, so tags and targets read as zero after reset.
            valid_q     <= '0;
            victim_q    <= '0;
            occupancy_q <= '0;
            full_q      <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            valid_q     <= valid_d;
            victim_q    <= victim_d;
            occupancy_q <= occupancy_d;
            full_q      <= (occupancy_d == OCC_W'(ENTRIES));
            tag_q       <= tag_d;
            target_q    <= target_d;
            ctr_q       <= ctr_d;
        end
    end

    // Lookup result registers. They read pre-update state, and hold when there is no request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_hit_q     <= 1'b0;
            lk_taken_q   <= 1'b0;
            lk_next_pc_q <= '0;
            lk_rvalid_q  <= 1'b0;
        end else if (lk_valid) begin
            lk_rvalid_q <= 1'b1;
            lk_hit_q    <= lk_match;
            lk_taken_q  <= lk_match & ctr_q[lk_idx][1];
            if (lk_match && ctr_q[lk_idx][1]) lk_next_pc_q <= target_q[lk_idx];
            else                              lk_next_pc_q <= lk_pc + ADDR_W'(PC_STEP);
        end else begin
            lk_rvalid_q <= 1'b0;
        end
    end

    assign lk_hit     = lk_hit_q;
    assign lk_taken   = lk_taken_q;
    assign lk_next_pc = lk_next_pc_q;
    assign lk_rvalid  = lk_rvalid_q;
    assign occupancy  = occupancy_q;
    assign full       = full_q;

endmodule

// File: tb/tb_btb_sat_predictor.sv
// Testbench for btb_sat_predictor. It runs directed scenarios and then
// random traffic. A behavioural table model predicts every output of the
// design.
module tb_btb_sat_predictor;

    localparam int ADDR_W  = 32;
    localparam int ENTRIES = 8;
    localparam int IDX_W   = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              lk_valid = 1'b0;
    logic [ADDR_W-1:0] lk_pc = '0;
    logic              lk_hit, lk_taken, lk_rvalid;
    logic [ADDR_W-1:0] lk_next_pc;
    logic              upd_valid = 1'b0;
    logic [ADDR_W-1:0] upd_pc = '0;
    logic [ADDR_W-1:0] upd_target = '0;
    logic              upd_taken = 1'b0;
    logic              flush = 1'b0;
    logic [IDX_W:0]    occupancy;
    logic              full;

    btb_sat_predictor #(
        .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .IDX_W(IDX_W), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lk_valid(lk_valid), .lk_pc(lk_pc),
        .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_next_pc(lk_next_pc), .lk_rvalid(lk_rvalid),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .flush(flush), .occupancy(occupancy), .full(full)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: a table of entries plus a round-robin pointer
    bit        m_valid [ENTRIES];
    bit [31:0] m_tag   [ENTRIES];
    bit [31:0] m_tgt   [ENTRIES];
    int        m_ctr   [ENTRIES];
    int        m_victim;
    bit        e_hit, e_taken, e_rvalid;
    bit [31:0] e_next;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_find(input bit [31:0] pc);
        for (int i = 0; i < ENTRIES; i++) if (m_valid[i] && m_tag[i] == pc) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < ENTRIES; i++) n += m_valid[i];
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
        m_victim = 0;
        e_hit = 0; e_taken = 0; e_rvalid = 0; e_next = 0;
    endtask

    // Model one clock edge: the lookup reads old state, then the update or flush is applied
    task automatic m_edge(input bit lv, input bit [31:0] lpc, input bit uv, input bit [31:0] upc,
                          input bit [31:0] utgt, input bit ut, input bit fl);
        int idx;
        e_rvalid = lv;
        if (lv) begin
            idx     = m_find(lpc);
            e_hit   = (idx >= 0);
            e_taken = e_hit && m_ctr[idx] >= 2;
            e_next  = e_taken ? m_tgt[idx] : lpc + 32'd4;
        end
        if (fl) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
            m_victim = 0;
        end else if (uv) begin
            idx = m_find(upc);
            if (idx >= 0) begin
                if (ut) begin
                    m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                    m_tgt[idx] = utgt;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
                end
            end else if (ut) begin
                if (m_count() < ENTRIES) begin
                    idx = 0;
                    while (m_valid[idx]) idx++;
                end else begin
                    idx = m_victim;
                    m_victim = (m_victim + 1) % ENTRIES;
                end
                m_valid[idx] = 1; m_tag[idx] = upc; m_tgt[idx] = utgt; m_ctr[idx] = 2;
            end
        end
    endtask

    // Drive one cycle at the falling edge, let the rising edge act, then compare at the next falling edge
    task automatic step(input logic lv, input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                        input logic [31:0] utgt, input logic ut, input logic fl);
        lk_valid = lv; lk_pc = lpc;
        upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = ut;
        flush = fl;
        m_edge(lv, lpc, uv, upc, utgt, ut, fl);
        @(posedge clk);
        @(negedge clk);
        check("lk_rvalid", lk_rvalid, e_rvalid);
        check("lk_hit", lk_hit, e_hit);
        check("lk_taken", lk_taken, e_taken);
        check("lk_next_pc", lk_next_pc, e_next);
        check("occupancy", occupancy, m_count());
        check("full", full, m_count() == ENTRIES);
    endtask

    task automatic lookup(input logic [31:0] pc);
        step(1, pc, 0, 0, 0, 0, 0);
    endtask

    task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        step(0, 0, 1, pc, tgt, tk, 0);
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        check("reset_rvalid", lk_rvalid, 0);
        check("reset_occupancy", occupancy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: cold miss
        lookup(32'h100);
        check("t1_next_pc", lk_next_pc, 32'h104);
        check("t1_hit", lk_hit, 0);

        // 2: allocate, then hit
        update(32'h100, 32'h200, 1);
        lookup(32'h100);
        check("t2_hit", lk_hit, 1);
        check("t2_next_pc", lk_next_pc, 32'h200);
        check("t2_occupancy", occupancy, 1);

        // 3a: two not-taken updates drop the counter to strongly not-taken
        update(32'h100, 32'h0, 0);
        update(32'h100, 32'h0, 0);
        lookup(32'h100);
        check("t3a_taken", lk_taken, 0);
        check("t3a_next_pc", lk_next_pc, 32'h104);
        // 3b: two taken updates bring it back to weakly taken
        update(32'h100, 32'h200, 1);
        update(32'h100, 32'h200, 1);
        lookup(32'h100);
        check("t3b_taken", lk_taken, 1);

        // 4a: flush, then fill the table
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < ENTRIES; i++) update(32'h1000 + 4 * i, 32'h8000 + 4 * i, 1);
        check("t4a_full", full, 1);
        // 4b: first replacement evicts slot 0
        update(32'h9000, 32'h9800, 1);
        lookup(32'h1000);
        check("t4b_evicted", lk_hit, 0);
        lookup(32'h1004);
        check("t4b_kept", lk_hit, 1);
        // 4c: ENTRIES more replacements wrap the pointer back to 1, so 0x9004 goes next
        for (int i = 0; i < ENTRIES; i++) update(32'h9004 + 4 * i, 32'h7000, 1);
        update(32'hA000, 32'hA800, 1);
        lookup(32'h9004);
        check("t4c_evicted", lk_hit, 0);
        lookup(32'h9008);
        check("t4c_kept", lk_hit, 1);

        // 5: lookup in the same cycle as the allocating update sees the old state
        step(1, 32'h300, 1, 32'h300, 32'h500, 1, 0);
        check("t5_same_cycle_hit", lk_hit, 0);
        lookup(32'h300);
        check("t5_next_hit", lk_hit, 1);
        check("t5_next_pc", lk_next_pc, 32'h500);

        // 6a: flush drops a same-cycle update; a same-cycle lookup still sees pre-flush state
        step(1, 32'h300, 1, 32'h700, 32'h800, 1, 1);
        check("t6a_preflush_hit", lk_hit, 1);
        check("t6a_occupancy", occupancy, 0);
        lookup(32'h700);
        check("t6a_dropped", lk_hit, 0);

        // 6b: fall-through wraps at the top of the address space
        lookup(32'hFFFF_FFFC);
        check("t6b_wrap", lk_next_pc, 32'h0);

        // 6c: asynchronous reset in the middle of an update
        update(32'h400, 32'h440, 1);
        lk_valid = 1; lk_pc = 32'h400;
        upd_valid = 1; upd_pc = 32'h500; upd_target = 32'h540; upd_taken = 1;
        #2 rst_n = 1'b0;
        #1;
        check("t6c_rvalid", lk_rvalid, 0);
        check("t6c_hit", lk_hit, 0);
        check("t6c_taken", lk_taken, 0);
        check("t6c_next_pc", lk_next_pc, 0);
        check("t6c_occupancy", occupancy, 0);
        check("t6c_full", full, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        lookup(32'h500);
        check("t6c_aborted", lk_hit, 0);

        // Random traffic over a small PC pool so that hits, fills and replacements all occur
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 32'h4000 + 4 * $urandom_range(0, 11),
                 $urandom_range(0, 1), 32'h4000 + 4 * $urandom_range(0, 11),
                 $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
